serial_comparator: RTL

//  Iterative magnitude comparator for the RV64 integer/FP-compare path; successor to the

---
 rtl/serial_comparator.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_comparator.sv
// Iterative MSB-first magnitude comparator: CHUNK bits per cycle, early exit on the
// first differing chunk, registered LT/EQ returned through a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; LT/EQ hold the last result
// CMP   | comparing the top chunk of the shifted operands, idx counts down to 0
// DONE  | one-cycle done pulse, busy still high, start ignored
module serial_comparator #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             SIGNED,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             LT,
    output logic             EQ
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             signed_q;
    logic [IW-1:0]    idx;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             top_chunk;

    // Operands shift left each step, so the active chunk is always the top slice;
    // idx only tracks how many chunks remain.
    always_comb begin
        top_chunk = (idx == IDX_TOP);
        chunk_a   = a_q[WIDTH-1 -: CHUNK];
        chunk_b   = b_q[WIDTH-1 -: CHUNK];
        if (signed_q && top_chunk) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            LT       <= 1'b0;
            EQ       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= A;
                        b_q      <= B;
                        signed_q <= SIGNED;
                        idx      <= IDX_TOP;
                        LT       <= 1'b0;
                        EQ       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CMP;
                    end
                end
                CMP: begin
                    if (chunk_a != chunk_b) begin
                        LT    <= (chunk_a < chunk_b);
                        EQ    <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (idx == '0) begin
                        LT    <= 1'b0;
                        EQ    <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                        a_q <= a_q << CHUNK;
                        b_q <= b_q << CHUNK;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
